// File: rtl/odd_parity_rx.sv
// odd_parity_rx: serial deframer and odd-parity checker for operand words.
// Ports:
//   clk       - system clock, rising edge
//   rst       - synchronous active-high reset
//   E         - receiver enable; low aborts any frame and returns to IDLE
//   bit_en    - bit-time strobe; rxd is only sampled when high
//   rxd       - serial line, idles high, frame = start/data(LSB first)/parity/stop
//   data_out  - last received word, held until the next frame completes
//   valid     - one-cycle pulse when data_out/par_err/frame_err are updated
//   par_err   - data ones plus parity bit were even for the flagged frame
//   frame_err - stop bit was sampled low for the flagged frame
//   busy      - receiver is inside a frame
//   err_cnt   - saturating count of frames with any error
module odd_parity_rx #(
    parameter int DATA_W    = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 E,
    input  logic                 bit_en,
    input  logic                 rxd,
    output logic [DATA_W-1:0]    data_out,
    output logic                 valid,
    output logic                 par_err,
    output logic                 frame_err,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t               state_q, state_d;
    logic [DATA_W-1:0]    shift_q, shift_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 par_q, par_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 busy_q;
    logic [ERR_CNT_W-1:0] ecnt_q, ecnt_d;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ecnt_d  = ecnt_q;
        if (!E) begin
            state_d = IDLE;
        end else if (bit_en) begin
            case (state_q)
                IDLE: begin
                    if (!rxd) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    shift_d[cnt_q] = rxd;
                    cnt_d          = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1))
                        state_d = PARITY;
                end
                PARITY: begin
                    par_d   = rxd;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    data_d  = shift_q;
                    // odd parity: total ones across data and parity must be odd
                    perr_d  = ~(^shift_q ^ par_q);
                    ferr_d  = ~rxd;
                    valid_d = 1'b1;
                    if ((perr_d || ferr_d) && ecnt_q != '1)
                        ecnt_d = ecnt_q + 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            busy_q  <= (state_d != IDLE);
            ecnt_q  <= ecnt_d;
        end
    end

    assign data_out  = data_q;
    assign valid     = valid_q;
    assign par_err   = perr_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;
    assign err_cnt   = ecnt_q;
endmodule
